// File: rtl/tekito_processing_unit.sv
// Single-cycle 4-bit core: fetches one byte per clock from an external combinational ROM
// and executes it on the same edge. Four registers, one flag, 6-bit PC, two I/O ports.
module tekito_processing_unit (
    input  logic       CLOCK,
    input  logic       RESET,
    output logic [5:0] MEMORY_ADDR,
    input  logic [7:0] MEMORY_DATA,
    input  logic [3:0] INPUT0,
    input  logic [3:0] INPUT1,
    output logic [3:0] OUTPUT0,
    output logic [3:0] OUTPUT1
);

    logic [5:0]      pc_q, pc_d;
    logic [3:0][3:0] regs_q, regs_d;
    logic            flag_q, flag_d;
    logic [3:0]      out0_q, out0_d;
    logic [3:0]      out1_q, out1_d;

    logic [1:0] dst_sel;
    logic [1:0] src_sel;
    logic [3:0] dst_val;
    logic [3:0] src_val;
    logic [4:0] sum5;
    logic [3:0] nand_res;

    assign MEMORY_ADDR = pc_q;
    assign OUTPUT0     = out0_q;
    assign OUTPUT1     = out1_q;

    // Both operands come from pre-edge register values, so d == s reads the old value twice.
    always_comb begin
        dst_sel  = MEMORY_DATA[3:2];
        src_sel  = MEMORY_DATA[1:0];
        dst_val  = regs_q[dst_sel];
        src_val  = regs_q[src_sel];
        sum5     = {1'b0, dst_val} + {1'b0, src_val};
        nand_res = ~(dst_val & src_val);

        pc_d   = pc_q + 6'd1;
        regs_d = regs_q;
        flag_d = flag_q;
        out0_d = out0_q;
        out1_d = out1_q;

        case (MEMORY_DATA[7:6])
            2'b00: begin
                case (MEMORY_DATA[5:4])
                    2'b00: regs_d[dst_sel] = src_val;
                    2'b01: begin
                        regs_d[dst_sel] = sum5[3:0];
                        flag_d          = sum5[4];
                    end
                    2'b10: begin
                        regs_d[dst_sel] = dst_val - src_val;
                        flag_d          = (src_val > dst_val);
                    end
                    default: begin
                        regs_d[dst_sel] = nand_res;
                        flag_d          = (nand_res == 4'd0);
                    end
                endcase
            end
            2'b01: regs_d[MEMORY_DATA[5:4]] = MEMORY_DATA[3:0];
            2'b10: begin
                if (!flag_q) begin
                    pc_d = MEMORY_DATA[5:0];
                end
            end
            default: begin
                case (MEMORY_DATA[5:4])
                    2'b00: regs_d[dst_sel] = MEMORY_DATA[1] ? INPUT1 : INPUT0;
                    2'b01: begin
                        if (MEMORY_DATA[1]) begin
                            out1_d = dst_val;
                        end else begin
                            out0_d = dst_val;
                        end
                    end
                    2'b10: flag_d = 1'b0;
                    default: flag_d = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pc_q   <= 6'd0;
            regs_q <= '0;
            flag_q <= 1'b0;
            out0_q <= 4'd0;
            out1_q <= 4'd0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            flag_q <= flag_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

endmodule

// File: tb/tb_tekito_processing_unit.sv
// Self-checking bench: per-edge expectations of {address, OUTPUT0, OUTPUT1} are queued
// when a program is loaded and popped after each executing edge.
module tb_tekito_processing_unit;

    logic       CLOCK;
    logic       RESET;
    logic [5:0] MEMORY_ADDR;
    logic [7:0] MEMORY_DATA;
    logic [3:0] INPUT0;
    logic [3:0] INPUT1;
    logic [3:0] OUTPUT0;
    logic [3:0] OUTPUT1;

    logic [7:0] rom [64];

    typedef struct packed {
        logic [5:0] addr;
        logic [3:0] o0;
        logic [3:0] o1;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step;

    tekito_processing_unit dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .MEMORY_ADDR (MEMORY_ADDR),
        .MEMORY_DATA (MEMORY_DATA),
        .INPUT0      (INPUT0),
        .INPUT1      (INPUT1),
        .OUTPUT0     (OUTPUT0),
        .OUTPUT1     (OUTPUT1)
    );

    assign MEMORY_DATA = rom[MEMORY_ADDR];

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    endtask

    task automatic push(input logic [5:0] a, input logic [3:0] o0, input logic [3:0] o1);
        sb.push_back('{addr: a, o0: o0, o1: o1});
    endtask

    // Holds reset across a falling edge so the ROM can be reloaded, then releases it.
    task automatic start_program();
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        RESET = 1'b0;
        #3;
        checks++;
        if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== 14'd0) begin
            errors++;
            $display("FAIL reset_initial: got addr/out0/out1 %h/%h/%h expected 00/0/0",
                     MEMORY_ADDR, OUTPUT0, OUTPUT1);
        end
        repeat (2) @(posedge CLOCK);
        #1;
        checks++;
        if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== 14'd0) begin
            errors++;
            $display("FAIL reset_held: got addr/out0/out1 %h/%h/%h expected 00/0/0",
                     MEMORY_ADDR, OUTPUT0, OUTPUT1);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        for (int i = 0; i < 64; i++) push(6'(i + 1), 4'h0, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL wrap step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    task automatic test_add_out();
        clear_rom();
        rom[0] = 8'h43; rom[1] = 8'h55; rom[2] = 8'h11; rom[3] = 8'hD0; rom[4] = 8'hB0;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'h0, 4'h0);
        push(6'h03, 4'h0, 4'h0);
        push(6'h04, 4'h8, 4'h0);
        push(6'h30, 4'h8, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL add_out step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    task automatic test_carry_jnf();
        clear_rom();
        rom[0] = 8'h4F; rom[1] = 8'hD0; rom[2] = 8'h51; rom[3] = 8'h11;
        rom[4] = 8'hA0; rom[5] = 8'hD0;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'hF, 4'h0);
        push(6'h03, 4'hF, 4'h0);
        push(6'h04, 4'hF, 4'h0);
        push(6'h05, 4'hF, 4'h0);
        push(6'h06, 4'h0, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL carry_no_jump step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end

        clear_rom();
        rom[0] = 8'h4F; rom[1] = 8'h51; rom[2] = 8'h11; rom[3] = 8'hE0;
        rom[4] = 8'hA0; rom[6'h20] = 8'hD0;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'h0, 4'h0);
        push(6'h03, 4'h0, 4'h0);
        push(6'h04, 4'h0, 4'h0);
        push(6'h20, 4'h0, 4'h0);
        push(6'h21, 4'h0, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL clf_jump step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    task automatic test_in_out();
        clear_rom();
        rom[0] = 8'hCA; rom[1] = 8'hC4; rom[2] = 8'hDA; rom[3] = 8'hD8; rom[4] = 8'hD4;
        INPUT1 = 4'hA;
        INPUT0 = 4'h3;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'h0, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL in_out step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
        // Port changes after the IN instructions must not reach the registers.
        INPUT1 = 4'h5;
        INPUT0 = 4'hF;
        push(6'h03, 4'h0, 4'hA);
        push(6'h04, 4'hA, 4'hA);
        push(6'h05, 4'h3, 4'hA);
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL in_out step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    task automatic test_sub_nand();
        clear_rom();
        rom[0] = 8'h42; rom[1] = 8'h55; rom[2] = 8'h21; rom[3] = 8'hD0; rom[4] = 8'hB0;
        rom[5] = 8'h6F; rom[6] = 8'hDA; rom[7] = 8'h3A; rom[8] = 8'hDA; rom[9] = 8'hB0;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'h0, 4'h0);
        push(6'h03, 4'h0, 4'h0);
        push(6'h04, 4'hD, 4'h0);
        push(6'h05, 4'hD, 4'h0);
        push(6'h06, 4'hD, 4'h0);
        push(6'h07, 4'hD, 4'hF);
        push(6'h08, 4'hD, 4'hF);
        push(6'h09, 4'hD, 4'h0);
        push(6'h0A, 4'hD, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL sub_nand step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        clear_rom();
        rom[0] = 8'h43; rom[1] = 8'h55; rom[2] = 8'h11; rom[3] = 8'hD0; rom[4] = 8'hF0;
        start_program();
        push(6'h01, 4'h0, 4'h0);
        push(6'h02, 4'h0, 4'h0);
        push(6'h03, 4'h0, 4'h0);
        push(6'h04, 4'h8, 4'h0);
        push(6'h05, 4'h8, 4'h0);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL mid_run step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got addr/out0/out1 %h/%h/%h expected 00/0/0",
                     MEMORY_ADDR, OUTPUT0, OUTPUT1);
        end
        // JNF at 0 proves FLAG cleared; NAND Rn,Rn then OUT shows ~Rn, so F means Rn was 0.
        clear_rom();
        rom[0] = 8'hA8;
        rom[6'h28] = 8'h30; rom[6'h29] = 8'h35; rom[6'h2A] = 8'h3A; rom[6'h2B] = 8'h3F;
        rom[6'h2C] = 8'hD0; rom[6'h2D] = 8'hD6; rom[6'h2E] = 8'hD8; rom[6'h2F] = 8'hDE;
        @(negedge CLOCK);
        RESET = 1'b1;
        push(6'h28, 4'h0, 4'h0);
        push(6'h29, 4'h0, 4'h0);
        push(6'h2A, 4'h0, 4'h0);
        push(6'h2B, 4'h0, 4'h0);
        push(6'h2C, 4'h0, 4'h0);
        push(6'h2D, 4'hF, 4'h0);
        push(6'h2E, 4'hF, 4'hF);
        push(6'h2F, 4'hF, 4'hF);
        push(6'h30, 4'hF, 4'hF);
        step = 0;
        while (sb.size() > 0) begin
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            step++;
            checks++;
            if ({MEMORY_ADDR, OUTPUT0, OUTPUT1} !== {e.addr, e.o0, e.o1}) begin
                errors++;
                $display("FAIL restart step %0d: got addr/out0/out1 %h/%h/%h expected %h/%h/%h",
                         step, MEMORY_ADDR, OUTPUT0, OUTPUT1, e.addr, e.o0, e.o1);
            end
        end
    endtask

    initial begin
        RESET  = 1'b0;
        INPUT0 = 4'h0;
        INPUT1 = 4'h0;
        test_reset();
        test_add_out();
        test_carry_jnf();
        test_in_out();
        test_sub_nand();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tekito_processing_unit.md
# tekito_processing_unit

Minimal 4-bit processor core with four general registers, one flag, a 6-bit program counter and two 4-bit input and output ports. It fetches one 8-bit instruction per clock from an external 64-entry combinational program ROM (the `MEMORY` block: `ADDR[5:0]` → `DATA[7:0]`, purely combinational, not part of this block) and executes it in the same cycle. It sits between the program ROM and board-level I/O.

## Interface
- No parameters.
- `CLOCK` in 1: single clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `MEMORY_ADDR` out 6: program ROM address, equal to PC (combinational from the PC register).
- `MEMORY_DATA` in 8: instruction word returned by the ROM for `MEMORY_ADDR`.
- `INPUT0`, `INPUT1` in 4: input ports, sampled only by IN instructions.
- `OUTPUT0`, `OUTPUT1` out 4: registered output ports, written only by OUT instructions.

## Operation
- State:
  - PC[5:0].
  - R0–R3, each [3:0].
  - FLAG.
  - OUT0 and OUT1 registers, each [3:0], driving `OUTPUT0` and `OUTPUT1`.
- Each rising `CLOCK` edge executes `MEMORY_DATA`, then PC ← PC+1 (mod 64) unless a taken jump loads PC.
- Encoding (d = destination register, s = source register, p = port):
  - `00 oo dd ss` ALU operation; operands are the pre-edge values of Rd and Rs:
    - oo=00 MOV: Rd ← Rs; FLAG unchanged.
    - oo=01 ADD: {FLAG, Rd} ← Rd + Rs (5-bit sum; FLAG = carry).
    - oo=10 SUB: Rd ← Rd − Rs mod 16; FLAG ← 1 if Rs > Rd (borrow), else 0.
    - oo=11 NAND: Rd ← ~(Rd & Rs); FLAG ← 1 if result == 0.
  - `01 dd iiii` LDI: Rd ← imm4; FLAG unchanged.
  - `10 aaaaaa` JNF: if FLAG == 0, PC ← a; otherwise PC ← PC+1. Unconditional jump = CLF followed by JNF.
  - `1100 dd p x` IN: Rd ← (p ? `INPUT1` : `INPUT0`).
  - `1101 ss p x` OUT: OUTp ← Rs.
  - `1110 xxxx` CLF: FLAG ← 0.
  - `1111 xxxx` STF: FLAG ← 1.
  - x bits are don't-care.
- No instruction other than the ALU operations, CLF and STF changes FLAG.
- No halt instruction. Execution continues forever; the PC wraps from 63 to 0.
- When d == s, the ALU uses the old value for both operands. For example, ADD R0,R0 doubles R0.
- Every instruction is one cycle. There are no stalls and no pipeline hazards.

## Timing
- While `RESET` = 0, asynchronously and regardless of `CLOCK`, the following are 0:
  - PC, so `MEMORY_ADDR` = 0.
  - R0–R3 and FLAG.
  - `OUTPUT0` and `OUTPUT1`.
- After `RESET` rises, the first rising `CLOCK` edge executes the word at address 0.
- Asserting `RESET` mid-program aborts the current instruction immediately. No partial writes survive.
- `MEMORY_ADDR` changes only after a rising edge (or on reset). The ROM has a full clock period to settle before the next edge.
- Latency:
  - OUT is visible on the output port right after its executing edge (1 cycle).
  - IN samples its input port at its executing edge; the value is usable by the next instruction.
- `INPUT0`/`INPUT1` changes between IN executions have no effect.

## Test plan
- Reset and wrap: ROM all 0x00 (MOV R0,R0) → during reset, `MEMORY_ADDR` = 0 and `OUTPUT0`/`OUTPUT1` = 0. After release, `MEMORY_ADDR` steps 1, 2, …, 63, 0 on successive edges; outputs stay 0.
- Add and output: ROM 0x43, 0x55, 0x11, 0xD0 (LDI R0,3; LDI R1,5; ADD R0,R1; OUT0 R0) → `OUTPUT0` = 8 after the 4th edge, FLAG = 0, `OUTPUT1` = 0.
- Carry and conditional jump:
  - ROM 0x4F, 0x51, 0x11, 0xA0 (LDI R0,F; LDI R1,1; ADD R0,R1; JNF 0x20) → R0 = 0, FLAG = 1, jump not taken, `MEMORY_ADDR` = 4.
  - With 0xE0 (CLF) inserted before the JNF → `MEMORY_ADDR` = 0x20 after the JNF.
- Input to output: `INPUT1` = 0xA, `INPUT0` = 0x3; ROM 0xCA, 0xC4, 0xDA, 0xD8 (IN R2,1; IN R1,0; OUT1 R2; OUT0 R2 → …) → `OUTPUT1` = 0xA after the 3rd edge. Check R1 = 3.
- SUB and NAND flags:
  - LDI R0,2; LDI R1,5; SUB R0,R1 (0x21) → R0 = 0xD, FLAG = 1.
  - LDI R2,F; NAND R2,R2 (0x3A) → R2 = 0, FLAG = 1.
- Reset mid-run: assert `RESET` low while `OUTPUT0` = 8 and PC = 5 → `OUTPUT0`, R0–R3, FLAG and `MEMORY_ADDR` clear to 0 immediately, without a clock edge. The program restarts from address 0 after release.
